// File: rtl/lcd_fill_sched.sv
// lcd_fill_sched: round-robin rectangle-fill scheduler for the ST7735 80x160 panel.
// Emits CASET/RASET/RAMWR followed by the pixel stream as a byte stream with D/C flag.
// Optional feature macro: LCD_FILL_SCHED_CLIP_EN (clip x1/y1 to the panel instead of rejecting).
`timescale 1ns/1ps
module lcd_fill_sched #(
    parameter int X_OFS  = 26,
    parameter int Y_OFS  = 1,
    parameter int WIDTH  = 80,
    parameter int HEIGHT = 160
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        lcd_ready,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rect,
    input  logic [15:0] req0_color,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rect,
    input  logic [15:0] req1_color,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        busy,
    output logic        gnt_id,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PIX_HI,
        S_PIX_LO,
        S_DONE
    } state_t;

    localparam logic [8:0] W_LIM = 9'(WIDTH);
    localparam logic [8:0] H_LIM = 9'(HEIGHT);

    state_t      r_state;
    state_t      w_next;

    logic        r_last;
    logic        r_gnt;
    logic        r_err;
    logic [7:0]  r_x0;
    logic [7:0]  r_x1;
    logic [7:0]  r_y0;
    logic [7:0]  r_y1;
    logic [15:0] r_color;
    logic [15:0] r_cnt;
    logic [3:0]  r_idx;

    logic        w_grant;
    logic        w_sel;
    logic        w_invalid;
    logic        w_active;
    logic        w_fire;
    logic [31:0] w_rect;
    logic [15:0] w_color;
    logic [7:0]  w_x0;
    logic [7:0]  w_x1;
    logic [7:0]  w_y0;
    logic [7:0]  w_y1;
    logic [7:0]  w_x1c;
    logic [7:0]  w_y1c;
    logic [8:0]  w_cols;
    logic [8:0]  w_rows;
    logic [15:0] w_area;

    // Requester 1 wins only when requester 0 is idle or was the last one served.
    assign w_sel   = ~(req0_valid & (~req1_valid | r_last));
    assign w_grant = (r_state == S_IDLE) & lcd_ready & (req0_valid | req1_valid);

    assign req0_ready = w_grant & ~w_sel;
    assign req1_ready = w_grant & w_sel;

    assign w_rect  = w_sel ? req1_rect  : req0_rect;
    assign w_color = w_sel ? req1_color : req0_color;
    assign w_x0    = w_rect[31:24];
    assign w_x1    = w_rect[23:16];
    assign w_y0    = w_rect[15:8];
    assign w_y1    = w_rect[7:0];

`ifdef LCD_FILL_SCHED_CLIP_EN
    localparam logic [7:0] X_MAX = 8'(WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT - 1);

    assign w_x1c     = ({1'b0, w_x1} >= W_LIM) ? X_MAX : w_x1;
    assign w_y1c     = ({1'b0, w_y1} >= H_LIM) ? Y_MAX : w_y1;
    assign w_invalid = (w_x0 > w_x1) | (w_y0 > w_y1) |
                       ({1'b0, w_x0} >= W_LIM) | ({1'b0, w_y0} >= H_LIM);
`else
    assign w_x1c     = w_x1;
    assign w_y1c     = w_y1;
    assign w_invalid = (w_x0 > w_x1) | (w_y0 > w_y1) |
                       ({1'b0, w_x1} >= W_LIM) | ({1'b0, w_y1} >= H_LIM);
`endif

    // Pixel count from the (possibly clipped) bounds; only meaningful for valid requests.
    assign w_cols = {1'b0, w_x1c} - {1'b0, w_x0} + 9'd1;
    assign w_rows = {1'b0, w_y1c} - {1'b0, w_y0} + 9'd1;
    assign w_area = 16'(w_cols) * 16'(w_rows);

    assign w_active   = (r_state == S_HDR) | (r_state == S_PIX_HI) | (r_state == S_PIX_LO);
    assign w_fire     = w_active & byte_ready;
    assign byte_valid = w_active;
    assign busy       = w_active;
    assign done       = (r_state == S_DONE);
    assign gnt_id     = r_gnt;
    assign err        = r_err;

    // State register; reset throws away any rectangle in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: advance only on accepted bytes so stalls hold everything.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant && !w_invalid) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                if (w_fire && (r_idx == 4'd10)) begin
                    w_next = S_PIX_HI;
                end
            end
            S_PIX_HI: begin
                if (w_fire) begin
                    w_next = S_PIX_LO;
                end
            end
            S_PIX_LO: begin
                if (w_fire) begin
                    w_next = (r_cnt == 16'd1) ? S_DONE : S_PIX_HI;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, request latch, header index and pixel down-counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
            r_x0    <= 8'h00;
            r_x1    <= 8'h00;
            r_y0    <= 8'h00;
            r_y1    <= 8'h00;
            r_color <= 16'h0000;
            r_cnt   <= 16'h0000;
            r_idx   <= 4'd0;
        end else begin
            r_err <= 1'b0;
            if (w_grant) begin
                r_last  <= w_sel;
                r_gnt   <= w_sel;
                r_err   <= w_invalid;
                r_x0    <= w_x0;
                r_x1    <= w_x1c;
                r_y0    <= w_y0;
                r_y1    <= w_y1c;
                r_color <= w_color;
                r_cnt   <= w_area;
                r_idx   <= 4'd0;
            end
            if (w_fire && (r_state == S_HDR)) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_fire && (r_state == S_PIX_LO)) begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    // Byte mux: header bytes by index, then colour high/low; zero when idle.
    always_comb begin
        byte_data = 8'h00;
        byte_dc   = 1'b0;
        case (r_state)
            S_HDR: begin
                case (r_idx)
                    4'd0:  begin byte_data = 8'h2A;               byte_dc = 1'b0; end
                    4'd1:  begin byte_data = 8'h00;               byte_dc = 1'b1; end
                    4'd2:  begin byte_data = r_x0 + 8'(X_OFS);    byte_dc = 1'b1; end
                    4'd3:  begin byte_data = 8'h00;               byte_dc = 1'b1; end
                    4'd4:  begin byte_data = r_x1 + 8'(X_OFS);    byte_dc = 1'b1; end
                    4'd5:  begin byte_data = 8'h2B;               byte_dc = 1'b0; end
                    4'd6:  begin byte_data = 8'h00;               byte_dc = 1'b1; end
                    4'd7:  begin byte_data = r_y0 + 8'(Y_OFS);    byte_dc = 1'b1; end
                    4'd8:  begin byte_data = 8'h00;               byte_dc = 1'b1; end
                    4'd9:  begin byte_data = r_y1 + 8'(Y_OFS);    byte_dc = 1'b1; end
                    4'd10: begin byte_data = 8'h2C;               byte_dc = 1'b0; end
                    default: begin byte_data = 8'h00;             byte_dc = 1'b0; end
                endcase
            end
            S_PIX_HI: begin
                byte_data = r_color[15:8];
                byte_dc   = 1'b1;
            end
            S_PIX_LO: begin
                byte_data = r_color[7:0];
                byte_dc   = 1'b1;
            end
            default: begin
                byte_data = 8'h00;
                byte_dc   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_fill_sched.sv
// tb_lcd_fill_sched: scoreboard bench for lcd_fill_sched (optionally built with LCD_FILL_SCHED_CLIP_EN).
`timescale 1ns/1ps
module tb_lcd_fill_sched;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        lcdReady = 1'b0;
    logic        req0Valid = 1'b0;
    logic        req1Valid = 1'b0;
    logic [31:0] req0Rect = 32'h0;
    logic [31:0] req1Rect = 32'h0;
    logic [15:0] req0Color = 16'h0;
    logic [15:0] req1Color = 16'h0;
    logic        byteReady = 1'b1;

    logic        req0Ready;
    logic        req1Ready;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteDc;
    logic        busy;
    logic        gntId;
    logic        done;
    logic        err;

    int          nCompared = 0;
    int          nMismatched = 0;
    bit          bpRandom = 1'b0;

    // Expected byte entries: {last, dc, data}; expected grants: {expErr, id}.
    logic [9:0]  byteQ[$];
    logic [1:0]  grantQ[$];

    bit          pendGrant = 1'b0;
    bit          pendErr = 1'b0;
    bit          pendId = 1'b0;
    bit          expectDone = 1'b0;
    int          grantsSeen = 0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic        prevR0 = 1'b0;
    logic        prevR1 = 1'b0;
    logic [8:0]  prevByte = 9'h0;

    logic [7:0]  spBytes [13] = '{8'h2A, 8'h00, 8'h1A, 8'h00, 8'h1A, 8'h2B, 8'h00,
                                  8'h01, 8'h00, 8'h01, 8'h2C, 8'hF8, 8'h00};
    bit          spDc [13]    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    lcd_fill_sched dut (
        .clk        (clk),
        .resetn     (resetn),
        .lcd_ready  (lcdReady),
        .req0_valid (req0Valid),
        .req0_ready (req0Ready),
        .req0_rect  (req0Rect),
        .req0_color (req0Color),
        .req1_valid (req1Valid),
        .req1_ready (req1Ready),
        .req1_rect  (req1Rect),
        .req1_color (req1Color),
        .byte_valid (byteValid),
        .byte_ready (byteReady),
        .byte_data  (byteData),
        .byte_dc    (byteDc),
        .busy       (busy),
        .gnt_id     (gntId),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(string name, int act, int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void pushByte(logic [7:0] d, logic dc, logic last);
        byteQ.push_back({last, dc, d});
    endfunction

    // Reference model of the byte stream for one valid rectangle.
    function automatic void pushRect(logic [31:0] rect, logic [15:0] col);
        int x0 = int'(rect[31:24]);
        int x1 = int'(rect[23:16]);
        int y0 = int'(rect[15:8]);
        int y1 = int'(rect[7:0]);
        int n;
`ifdef LCD_FILL_SCHED_CLIP_EN
        if (x1 > 79) x1 = 79;
        if (y1 > 159) y1 = 159;
`endif
        pushByte(8'h2A, 1'b0, 1'b0);
        pushByte(8'h00, 1'b1, 1'b0);
        pushByte(8'(x0 + 26), 1'b1, 1'b0);
        pushByte(8'h00, 1'b1, 1'b0);
        pushByte(8'(x1 + 26), 1'b1, 1'b0);
        pushByte(8'h2B, 1'b0, 1'b0);
        pushByte(8'h00, 1'b1, 1'b0);
        pushByte(8'(y0 + 1), 1'b1, 1'b0);
        pushByte(8'h00, 1'b1, 1'b0);
        pushByte(8'(y1 + 1), 1'b1, 1'b0);
        pushByte(8'h2C, 1'b0, 1'b0);
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int i = 0; i < n; i++) begin
            pushByte(col[15:8], 1'b1, 1'b0);
            pushByte(col[7:0], 1'b1, (i == n - 1));
        end
    endfunction

    // Present one request, wait for its accept strobe, then withdraw it.
    task automatic applyStimulus(input int id, input logic [31:0] rect, input logic [15:0] col,
                                 input bit expErr);
        int k;
        grantQ.push_back({expErr, id[0]});
        @(posedge clk);
        #1;
        if (id == 0) begin
            req0Rect = rect; req0Color = col; req0Valid = 1'b1;
        end else begin
            req1Rect = rect; req1Color = col; req1Valid = 1'b1;
        end
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((id == 0) ? req0Ready : req1Ready) break;
        end
        checkOutput("grantWait", int'(k < 50), 1);
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (byteQ.size() == 0 && grantQ.size() == 0 && !pendGrant && !expectDone && !busy) break;
        end
        checkOutput("drained", byteQ.size() + grantQ.size() + int'(busy) + int'(expectDone), 0);
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT grants or hands over a byte.
    always @(negedge clk) begin
        if (!resetn) begin
            pendGrant  = 1'b0;
            expectDone = 1'b0;
            prevValid  = 1'b0;
            prevReady  = 1'b0;
            prevR0     = 1'b0;
            prevR1     = 1'b0;
        end else begin
            if (done || expectDone) checkOutput("done", int'(done), int'(expectDone));
            expectDone = 1'b0;
            if (pendGrant) begin
                if (pendErr) begin
                    checkOutput("err", int'(err), 1);
                end else begin
                    checkOutput("grantBusy", int'({busy, byteValid}), 3);
                    checkOutput("gntId", int'(gntId), int'(pendId));
                    checkOutput("errQuiet", int'(err), 0);
                end
                pendGrant = 1'b0;
            end else if (err) begin
                checkOutput("errSpurious", int'(err), 0);
            end
            if (req0Ready || req1Ready) begin
                grantsSeen++;
                checkOutput("readyPulse", int'({prevR1 & req1Ready, prevR0 & req0Ready}), 0);
                if (grantQ.size() == 0) begin
                    checkOutput("grantQueued", grantQ.size(), 1);
                end else begin
                    logic [1:0] g;
                    g = grantQ.pop_front();
                    checkOutput("grantReadys", int'({req1Ready, req0Ready}), g[0] ? 2 : 1);
                    pendGrant = 1'b1;
                    pendErr   = g[1];
                    pendId    = g[0];
                end
            end
            if (prevValid && !prevReady) begin
                checkOutput("stallValid", int'(byteValid), 1);
                checkOutput("stallData", int'({byteDc, byteData}), int'(prevByte));
            end
            if (byteValid && byteReady) begin
                if (byteQ.size() == 0) begin
                    checkOutput("byteQueued", byteQ.size(), 1);
                end else begin
                    logic [9:0] e;
                    e = byteQ.pop_front();
                    checkOutput("byte", int'({busy, byteDc, byteData}), int'({1'b1, e[8:0]}));
                    if (e[9]) expectDone = 1'b1;
                end
            end
            prevValid = byteValid;
            prevReady = byteReady;
            prevByte  = {byteDc, byteData};
            prevR0    = req0Ready;
            prevR1    = req1Ready;
        end
    end

    // Serializer model: always ready, or randomly stalling during the backpressure phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            byteReady = bpRandom ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g0;
        int k;

        // Reset values, with both requesters already waiting.
        req0Rect = 32'h01010202; req0Color = 16'h1234; req0Valid = 1'b1;
        req1Rect = 32'h03030404; req1Color = 16'h5678; req1Valid = 1'b1;
        #12;
        checkOutput("rstByteValid", int'(byteValid), 0);
        checkOutput("rstByteData", int'(byteData), 0);
        checkOutput("rstByteDc", int'(byteDc), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstGntId", int'(gntId), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstErr", int'(err), 0);
        checkOutput("rstReady0", int'(req0Ready), 0);
        checkOutput("rstReady1", int'(req1Ready), 0);
        #10;
        resetn = 1'b1;

        // Round-robin with both requesters held: 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            grantQ.push_back({1'b0, i[0]});
            if (i[0]) pushRect(32'h03030404, 16'h5678);
            else      pushRect(32'h01010202, 16'h1234);
        end
        @(posedge clk);
        #1;
        lcdReady = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (grantQ.size() == 0) break;
        end
        checkOutput("rrGrants", grantsSeen, 4);
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        waitDrain(200);

        // lcd_ready low blocks grants; raising it lets the pending request through.
        lcdReady = 1'b0;
        g0 = grantsSeen;
        req0Rect = 32'h02020303; req0Color = 16'hBEEF; req0Valid = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("gatedGrants", grantsSeen - g0, 0);
        grantQ.push_back(2'b00);
        pushRect(32'h02020303, 16'hBEEF);
        @(posedge clk);
        #1;
        lcdReady = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req0Ready) break;
        end
        checkOutput("ungatedGrant", int'(k < 20), 1);
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        waitDrain(200);

        // Single pixel at the origin, hand-listed byte stream.
        for (int i = 0; i < 13; i++) pushByte(spBytes[i], spDc[i], (i == 12));
        applyStimulus(0, 32'h00000000, 16'hF800, 1'b0);
        waitDrain(200);

        // Full screen.
        pushRect(32'h004F009F, 16'h07E0);
        applyStimulus(0, 32'h004F009F, 16'h07E0, 1'b0);
        waitDrain(30000);

        // Invalid: x0 > x1.
        applyStimulus(1, 32'h05040000, 16'hFFFF, 1'b1);
        waitDrain(50);

        // x1 beyond the panel: clipped or rejected depending on the build.
`ifdef LCD_FILL_SCHED_CLIP_EN
        pushRect(32'h005A0000, 16'h001F);
        applyStimulus(1, 32'h005A0000, 16'h001F, 1'b0);
`else
        applyStimulus(1, 32'h005A0000, 16'h001F, 1'b1);
`endif
        waitDrain(500);

        // Random backpressure.
        bpRandom = 1'b1;
        pushRect(32'h0A0C1415, 16'h3C5A);
        applyStimulus(0, 32'h0A0C1415, 16'h3C5A, 1'b0);
        waitDrain(1000);
        bpRandom = 1'b0;

        // Reset in the middle of the pixel stream, then a clean restart.
        pushRect(32'h004F0009, 16'hABCD);
        applyStimulus(0, 32'h004F0009, 16'hABCD, 1'b0);
        repeat (30) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("midRstValid", int'(byteValid), 0);
        checkOutput("midRstBusy", int'(busy), 0);
        byteQ.delete();
        grantQ.delete();
        pendGrant  = 1'b0;
        expectDone = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        pushRect(32'h02030405, 16'h0F0F);
        applyStimulus(1, 32'h02030405, 16'h0F0F, 1'b0);
        waitDrain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lcd_fill_sched.md
# lcd_fill_sched

Rectangle-fill scheduler for the 0.96" 80x160 ST7735 PMOD LCD. It arbitrates between two requesters that want solid-colour rectangles drawn. For each granted request it emits the CASET/RASET/RAMWR command sequence followed by the pixel stream as a byte stream with a D/C flag. A downstream SPI byte serializer consumes the stream, and the block only starts work once the panel init sequencer reports the display ready.

## Interface

Parameters:
- X_OFS, 26: panel column offset added to x coordinates.
- Y_OFS, 1: panel row offset added to y coordinates.
- WIDTH, 80: visible columns. Valid x is 0..WIDTH-1.
- HEIGHT, 160: visible rows. Valid y is 0..HEIGHT-1.

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: asynchronous, active-low reset.
- lcd_ready, input, 1: init sequencer done. While low, no new grants are issued.
- req0_valid, input, 1: requester 0 has a rectangle pending.
- req0_ready, output, 1: one-cycle accept strobe for requester 0.
- req0_rect, input, 32: {x0, x1, y0, y1}, 8 bits each, inclusive bounds.
- req0_color, input, 16: RGB565 fill colour.
- req1_valid, req1_ready, req1_rect, req1_color: same as the requester 0 ports, for requester 1.
- byte_valid, output, 1: byte_data/byte_dc hold a byte for the serializer.
- byte_ready, input, 1: serializer accepts the byte on this cycle.
- byte_data, output, 8: byte to shift, MSB first.
- byte_dc, output, 1: 0 = command byte, 1 = data byte.
- busy, output, 1: a rectangle is in progress.
- gnt_id, output, 1: requester being served. Valid while busy.
- done, output, 1: one-cycle pulse after the last pixel byte is accepted.
- err, output, 1: one-cycle pulse when a request is accepted but rejected as invalid.

## Operation

- A byte transfers when byte_valid && byte_ready. While byte_valid is high and not accepted, byte_data and byte_dc stay stable.
- States: IDLE → HDR → PIX_HI → PIX_LO → DONE → IDLE.
- IDLE:
  - Grant only if lcd_ready is high and at least one reqN_valid is high.
  - Round-robin: with both requesters valid, grant the one not served last. The last-served pointer resets to 1, so requester 0 wins first.
  - On grant: pulse reqN_ready for one cycle, latch rect and colour, set gnt_id.
  - Validate the latched request: invalid if x0 > x1, y0 > y1, x1 ≥ WIDTH or y1 ≥ HEIGHT.
  - Invalid: pulse err the next cycle, emit no bytes, stay in IDLE.
  - Valid: go to HDR.
- HDR emits 11 bytes, indexed 0..10:
  - 2A (dc=0), 00, x0+X_OFS, 00, x1+X_OFS (dc=1).
  - 2B (dc=0), 00, y0+Y_OFS, 00, y1+Y_OFS (dc=1).
  - 2C (dc=0).
  - Address sums are 8-bit; they cannot overflow with the default parameters.
- Pixel count N = (x1-x0+1)*(y1-y0+1), held in a 16-bit down-counter. The maximum is 12800.
- PIX_HI emits color[15:8] with dc=1. PIX_LO emits color[7:0] with dc=1, then decrements N. The block returns to PIX_HI while N ≠ 0 after the decrement, otherwise it goes to DONE.
- DONE pulses done for one cycle and returns to IDLE. busy drops on the same cycle.
- If lcd_ready drops mid-rectangle, the block ignores it and completes the rectangle. No grant is issued afterwards until lcd_ready returns high.
- If byte_ready is held low, the block stalls indefinitely with no timeout.

## Timing

- Reset values:
  - All outputs 0: byte_valid, byte_data = 00, byte_dc, busy, gnt_id, done, err, req0_ready, req1_ready.
  - State IDLE.
- Reset mid-rectangle clears the block asynchronously. byte_valid goes low immediately and the rest of the rectangle is discarded.
- Grant cycle T: reqN_ready = 1.
  - Valid request: busy = 1 and byte_valid = 1 with byte 2A at T+1.
  - Invalid request: err = 1 at T+1.
- Throughput is one byte per cycle when byte_ready is held high.
- A valid rectangle takes 11 + 2N accepted bytes. done pulses the cycle after the final accept.
- The earliest next grant is the cycle after done. A requester whose valid is held continuously is granted again no earlier than that.

## Configuration

- LCD_FILL_SCHED_CLIP_EN, defined:
  - x1 and y1 beyond the panel are clipped to WIDTH-1 and HEIGHT-1 before the header and N are computed.
  - Only x0 > x1, y0 > y1, x0 ≥ WIDTH or y0 ≥ HEIGHT raise err.
- LCD_FILL_SCHED_CLIP_EN, undefined: any out-of-range coordinate raises err, per the IDLE rules.

## Test plan

- Single pixel, req0 rect {0,0,0,0}, colour F800, byte_ready = 1:
  - Bytes 2A 00 1A 00 1A 2B 00 01 00 01 2C F8 00.
  - dc = 0,1,1,1,1,0,1,1,1,1,0,1,1.
  - done one cycle after the last byte.
- Full screen, rect {0,79,0,159}, colour 07E0:
  - 25611 bytes; the header carries 1A/69 and 01/A0.
  - done fires once; busy high throughout.
- Both requesters valid from reset, each with a 1x1 rect: grants alternate 0,1,0,1. gnt_id matches and each ready pulse is one cycle long.
- Invalid request rect {5,4,0,0}: err pulses, no byte_valid, state returns to IDLE. With LCD_FILL_SCHED_CLIP_EN and rect {0,90,0,0}, the header x1 byte is 69 and 160 pixel bytes are emitted.
- Backpressure and gating:
  - byte_ready toggling randomly: the byte sequence is identical to the unstalled case, with data stable while stalled.
  - lcd_ready = 0: no grant is issued.
- Reset asserted mid-pixel stream: byte_valid is 0 immediately. After release, a new request starts cleanly with 2A.
